// File: rtl/regex_job_sched.sv
// Queues regex scan jobs and dispatches them round-robin to a pool of NUM_UNITS accelerator units.
// Defining REGEX_JOB_SCHED_STATS_EN adds the stat_jobs / stat_matches / stat_stall_cycles counters.
module regex_job_sched #(
   parameter int NUM_UNITS      = 4,
   parameter int ADDR_WIDTH     = 8,
   parameter int LEN_WIDTH      = 16,
   parameter int TAG_WIDTH      = 8,
   parameter int CMD_FIFO_DEPTH = 8,
   parameter int RES_FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_WIDTH-1:0]            s_cmd_addr,
   input  logic [LEN_WIDTH-1:0]             s_cmd_len,
   input  logic [TAG_WIDTH-1:0]             s_cmd_tag,
   input  logic                             s_cmd_valid,
   output logic                             s_cmd_ready,
   output logic [NUM_UNITS*ADDR_WIDTH-1:0]  u_cmd_addr,
   output logic [NUM_UNITS*LEN_WIDTH-1:0]   u_cmd_len,
   output logic [NUM_UNITS-1:0]             u_cmd_valid,
   input  logic [NUM_UNITS-1:0]             u_cmd_ready,
   input  logic [NUM_UNITS-1:0]             u_status_done,
   input  logic [NUM_UNITS-1:0]             u_status_match,
   output logic [TAG_WIDTH-1:0]             m_res_tag,
   output logic                             m_res_match,
   output logic [$clog2(NUM_UNITS)-1:0]     m_res_unit,
   output logic                             m_res_valid,
   input  logic                             m_res_ready,
   output logic [NUM_UNITS-1:0]             busy_mask,
   output logic [$clog2(CMD_FIFO_DEPTH):0]  cmd_count
`ifdef REGEX_JOB_SCHED_STATS_EN
   ,
   output logic [31:0]                      stat_jobs,
   output logic [31:0]                      stat_matches,
   output logic [31:0]                      stat_stall_cycles
`endif
);

   localparam int UW  = $clog2(NUM_UNITS);
   localparam int CAW = $clog2(CMD_FIFO_DEPTH);
   localparam int RAW = $clog2(RES_FIFO_DEPTH);
   localparam int RW  = TAG_WIDTH + 1 + UW;
   localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_FIFO_DEPTH);
   localparam logic [RAW:0] RES_FULL = (RAW+1)'(RES_FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, RUN, REPORT} unit_state_t;

   // First requester at or after ptr, wrapping; the descending scan lets the lowest offset win.
   function automatic logic [UW-1:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                             input logic [UW-1:0]        ptr);
      logic [UW-1:0] pick;
      logic [UW-1:0] sel;
      int            idx;
      pick = '0;
      for (int i = NUM_UNITS-1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
         sel = UW'(idx);
         if (req[sel]) pick = sel;
      end
      return pick;
   endfunction

   function automatic logic [UW-1:0] rr_next(input logic [UW-1:0] sel);
      return (int'(sel) == NUM_UNITS-1) ? '0 : sel + UW'(1);
   endfunction

   logic [ADDR_WIDTH-1:0] cmd_addr_mem [CMD_FIFO_DEPTH];
   logic [LEN_WIDTH-1:0]  cmd_len_mem  [CMD_FIFO_DEPTH];
   logic [TAG_WIDTH-1:0]  cmd_tag_mem  [CMD_FIFO_DEPTH];
   logic [CAW-1:0]        cmd_wr_ptr;
   logic [CAW-1:0]        cmd_rd_ptr;
   logic                  cmd_push;
   logic                  cmd_pop;
   logic                  cmd_empty;

   logic [RW-1:0]         res_mem [RES_FIFO_DEPTH];
   logic [RAW-1:0]        res_wr_ptr;
   logic [RAW-1:0]        res_rd_ptr;
   logic [RAW:0]          res_count;
   logic                  res_pop;
   logic                  res_space;
   logic                  res_push;

   unit_state_t           state     [NUM_UNITS];
   unit_state_t           state_nxt [NUM_UNITS];
   logic [ADDR_WIDTH-1:0] addr_q    [NUM_UNITS];
   logic [LEN_WIDTH-1:0]  len_q     [NUM_UNITS];
   logic [TAG_WIDTH-1:0]  tag_q     [NUM_UNITS];
   logic [NUM_UNITS-1:0]  match_q;

   logic [NUM_UNITS-1:0]  idle_vec;
   logic [NUM_UNITS-1:0]  rep_vec;
   logic [UW-1:0]         disp_ptr;
   logic [UW-1:0]         disp_sel;
   logic                  disp_fire;
   logic [UW-1:0]         res_ptr;
   logic [UW-1:0]         res_sel;

   assign cmd_empty   = (cmd_count == '0);
   assign s_cmd_ready = (cmd_count != CMD_FULL);
   assign cmd_push    = s_cmd_valid && s_cmd_ready;
   assign cmd_pop     = disp_fire;

   always_comb begin
      idle_vec = '0;
      rep_vec  = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         idle_vec[i] = (state[i] == IDLE);
         rep_vec[i]  = (state[i] == REPORT);
      end
   end

   assign disp_fire = !cmd_empty && (|idle_vec);
   assign disp_sel  = rr_pick(idle_vec, disp_ptr);

   // A full result FIFO still accepts a push when the head is being popped in the same cycle.
   assign m_res_valid = (res_count != '0);
   assign res_pop     = m_res_valid && m_res_ready;
   assign res_space   = (res_count != RES_FULL) || res_pop;
   assign res_push    = (|rep_vec) && res_space;
   assign res_sel     = rr_pick(rep_vec, res_ptr);

   assign {m_res_tag, m_res_match, m_res_unit} = res_mem[res_rd_ptr];
   assign busy_mask = ~idle_vec;

   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         state_nxt[i] = state[i];
         unique case (state[i])
            IDLE:    if (disp_fire && disp_sel == UW'(i)) state_nxt[i] = ISSUE;
            ISSUE:   if (u_cmd_ready[i])                  state_nxt[i] = RUN;
            RUN:     if (u_status_done[i])                state_nxt[i] = REPORT;
            REPORT:  if (res_push && res_sel == UW'(i))   state_nxt[i] = IDLE;
            default:                                      state_nxt[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (rst) state[i] <= IDLE;
         else     state[i] <= state_nxt[i];
      end
   end

   always_comb begin
      u_cmd_valid = '0;
      u_cmd_addr  = '0;
      u_cmd_len   = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         u_cmd_valid[i]                         = (state[i] == ISSUE);
         u_cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[i];
         u_cmd_len[i*LEN_WIDTH +: LEN_WIDTH]    = len_q[i];
      end
   end

   // Control state: FIFO pointers, occupancies and round-robin pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_count  <= '0;
         res_wr_ptr <= '0;
         res_rd_ptr <= '0;
         res_count  <= '0;
         disp_ptr   <= '0;
         res_ptr    <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
         cmd_count <= cmd_count + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
         if (res_push) res_wr_ptr <= res_wr_ptr + RAW'(1);
         if (res_pop)  res_rd_ptr <= res_rd_ptr + RAW'(1);
         res_count <= res_count + (RAW+1)'(res_push) - (RAW+1)'(res_pop);
         if (disp_fire) disp_ptr <= rr_next(disp_sel);
         if (res_push)  res_ptr  <= rr_next(res_sel);
      end
   end

   // Datapath storage: FIFO payloads and per-unit job registers, not reset.
   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_addr_mem[cmd_wr_ptr] <= s_cmd_addr;
         cmd_len_mem[cmd_wr_ptr]  <= s_cmd_len;
         cmd_tag_mem[cmd_wr_ptr]  <= s_cmd_tag;
      end
      if (res_push) res_mem[res_wr_ptr] <= {tag_q[res_sel], match_q[res_sel], res_sel};
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (disp_fire && disp_sel == UW'(i)) begin
            addr_q[i] <= cmd_addr_mem[cmd_rd_ptr];
            len_q[i]  <= cmd_len_mem[cmd_rd_ptr];
            tag_q[i]  <= cmd_tag_mem[cmd_rd_ptr];
         end
         if (state[i] == RUN && u_status_done[i]) match_q[i] <= u_status_match[i];
      end
   end

`ifdef REGEX_JOB_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_jobs         <= '0;
         stat_matches      <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (res_push)                     stat_jobs         <= stat_jobs + 32'd1;
         if (res_push && match_q[res_sel]) stat_matches      <= stat_matches + 32'd1;
         if (!cmd_empty && !(|idle_vec))   stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_regex_job_sched.sv
// Directed bench for regex_job_sched: stimulus queues expected results, a negedge monitor pops and compares them.
module tb_regex_job_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_cmd_addr;
   logic [15:0] s_cmd_len;
   logic [7:0]  s_cmd_tag;
   logic        s_cmd_valid;
   logic        s_cmd_ready;
   logic [31:0] u_cmd_addr;
   logic [63:0] u_cmd_len;
   logic [3:0]  u_cmd_valid;
   logic [3:0]  u_cmd_ready;
   logic [3:0]  u_status_done;
   logic [3:0]  u_status_match;
   logic [7:0]  m_res_tag;
   logic        m_res_match;
   logic [1:0]  m_res_unit;
   logic        m_res_valid;
   logic        m_res_ready;
   logic [3:0]  busy_mask;
   logic [3:0]  cmd_count;
`ifdef REGEX_JOB_SCHED_STATS_EN
   logic [31:0] stat_jobs;
   logic [31:0] stat_matches;
   logic [31:0] stat_stall_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   regex_job_sched dut (
      .clk(clk), .rst(rst),
      .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len), .s_cmd_tag(s_cmd_tag),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .u_cmd_addr(u_cmd_addr), .u_cmd_len(u_cmd_len), .u_cmd_valid(u_cmd_valid),
      .u_cmd_ready(u_cmd_ready), .u_status_done(u_status_done), .u_status_match(u_status_match),
      .m_res_tag(m_res_tag), .m_res_match(m_res_match), .m_res_unit(m_res_unit),
      .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
      .busy_mask(busy_mask), .cmd_count(cmd_count)
`ifdef REGEX_JOB_SCHED_STATS_EN
      , .stat_jobs(stat_jobs), .stat_matches(stat_matches), .stat_stall_cycles(stat_stall_cycles)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [7:0] tag, input logic match, input logic [1:0] unit);
      exp_q.push_back({tag, match, unit});
   endtask

   task automatic push_job(input logic [7:0] addr, input logic [15:0] len, input logic [7:0] tag);
      s_cmd_valid = 1'b1;
      s_cmd_addr  = addr;
      s_cmd_len   = len;
      s_cmd_tag   = tag;
      tick();
      s_cmd_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [3:0] mask, input logic [3:0] match);
      u_status_done  = mask;
      u_status_match = match;
      tick();
      u_status_done  = '0;
      u_status_match = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One batch of four completions: release all ISSUE units, then pulse done on all four.
   task automatic run_round(input logic [3:0] pattern, input logic [7:0] base_tag);
      u_cmd_ready = 4'hF;
      tick();
      u_cmd_ready = 4'h0;
      for (int u = 0; u < 4; u++) exp_push(base_tag + 8'(u), pattern[u], 2'(u));
      pulse_done(4'hF, pattern);
      repeat (6) tick();
   endtask

   always @(negedge clk) begin
      if (!rst && m_res_valid && m_res_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL res_unexpected: got tag 0x%0h unit %0d, required no result", m_res_tag, m_res_unit);
         end else begin
            check("res_entry", 64'({m_res_tag, m_res_match, m_res_unit}), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_cmd_addr = '0; s_cmd_len = '0; s_cmd_tag = '0; s_cmd_valid = 1'b0;
      u_cmd_ready = '0; u_status_done = '0; u_status_match = '0; m_res_ready = 1'b1;
      tick();
      tick();
      check("rst_u_cmd_valid", 64'(u_cmd_valid), 64'(0));
      check("rst_m_res_valid", 64'(m_res_valid), 64'(0));
      check("rst_busy", 64'(busy_mask), 64'(0));
      check("rst_cmd_count", 64'(cmd_count), 64'(0));
      check("rst_s_cmd_ready", 64'(s_cmd_ready), 64'(1));
      rst = 1'b0;

      // Test 1: single job end to end
      u_cmd_ready = 4'b0001;
      push_job(8'h10, 16'd64, 8'h5A);
      check("t1_count_after_push", 64'(cmd_count), 64'(1));
      check("t1_no_valid_yet", 64'(u_cmd_valid), 64'(0));
      tick();
      check("t1_u_cmd_valid", 64'(u_cmd_valid), 64'(4'b0001));
      check("t1_addr", 64'(u_cmd_addr[7:0]), 64'(8'h10));
      check("t1_len", 64'(u_cmd_len[15:0]), 64'(16'd64));
      check("t1_busy_issue", 64'(busy_mask), 64'(4'b0001));
      check("t1_count_popped", 64'(cmd_count), 64'(0));
      tick();
      check("t1_run_valid_low", 64'(u_cmd_valid), 64'(0));
      u_cmd_ready = '0;
      repeat (9) tick();
      exp_push(8'h5A, 1'b1, 2'd0);
      pulse_done(4'b0001, 4'b0001);
      check("t1_report_no_res", 64'(m_res_valid), 64'(0));
      check("t1_busy_report", 64'(busy_mask), 64'(4'b0001));
      tick();
      check("t1_res_valid", 64'(m_res_valid), 64'(1));
      check("t1_res_tag", 64'(m_res_tag), 64'(8'h5A));
      check("t1_res_match", 64'(m_res_match), 64'(1));
      check("t1_res_unit", 64'(m_res_unit), 64'(0));
      check("t1_busy_idle", 64'(busy_mask), 64'(0));
      tick();
      check("t1_res_drained", 64'(m_res_valid), 64'(0));

      // Test 2: fill units and command FIFO
      do_reset();
      for (int t = 0; t < 8; t++) begin
         check("t2_ready_open", 64'(s_cmd_ready), 64'(1));
         push_job(8'h20 + 8'(t), 16'(t), 8'(t));
      end
      check("t2_units_valid", 64'(u_cmd_valid), 64'(4'hF));
      check("t2_unit_addrs", 64'(u_cmd_addr), 64'(32'h23222120));
      check("t2_unit_lens", 64'(u_cmd_len), 64'({16'd3, 16'd2, 16'd1, 16'd0}));
      check("t2_count4", 64'(cmd_count), 64'(4));
      check("t2_ready_still", 64'(s_cmd_ready), 64'(1));
      for (int t = 8; t < 12; t++) push_job(8'h20 + 8'(t), 16'(t), 8'(t));
      check("t2_count_full", 64'(cmd_count), 64'(8));
      check("t2_ready_full", 64'(s_cmd_ready), 64'(0));
      push_job(8'hEE, 16'hEEEE, 8'hEE);
      check("t2_full_rejects", 64'(cmd_count), 64'(8));

      // Test 3: simultaneous done on all four units
      u_cmd_ready = 4'hF;
      tick();
      u_cmd_ready = 4'h0;
      exp_push(8'd0, 1'b1, 2'd0);
      exp_push(8'd1, 1'b0, 2'd1);
      exp_push(8'd2, 1'b1, 2'd2);
      exp_push(8'd3, 1'b0, 2'd3);
      pulse_done(4'hF, 4'b0101);
      tick();
      check("t3_res_c1", 64'(m_res_valid), 64'(1));
      tick();
      check("t3_res_c2", 64'(m_res_valid), 64'(1));
      check("t3_ready_reopen", 64'(s_cmd_ready), 64'(1));
      check("t3_count7", 64'(cmd_count), 64'(7));
      tick();
      check("t3_res_c3", 64'(m_res_valid), 64'(1));
      tick();
      check("t3_res_c4", 64'(m_res_valid), 64'(1));
      tick();
      check("t3_res_done", 64'(m_res_valid), 64'(0));
      check("t3_redispatch", 64'(u_cmd_valid), 64'(4'hF));
      check("t3_count4", 64'(cmd_count), 64'(4));
`ifdef REGEX_JOB_SCHED_STATS_EN
      check("t3_stat_jobs", 64'(stat_jobs), 64'(4));
      check("t3_stat_matches", 64'(stat_matches), 64'(2));
`endif

      // Test 4: result back-pressure over 12 completions
      m_res_ready = 1'b0;
      for (int t = 12; t < 16; t++) push_job(8'h20 + 8'(t), 16'(t), 8'(t));
      check("t4_count8", 64'(cmd_count), 64'(8));
      run_round(4'b0011, 8'd4);
      run_round(4'b1000, 8'd8);
      run_round(4'b0110, 8'd12);
      push_job(8'h30, 16'd16, 8'h10);
      check("t4_busy_all", 64'(busy_mask), 64'(4'hF));
      check("t4_no_dispatch", 64'(u_cmd_valid), 64'(0));
      check("t4_queued", 64'(cmd_count), 64'(1));
      check("t4_res_valid", 64'(m_res_valid), 64'(1));
      check("t4_head_tag", 64'(m_res_tag), 64'(8'd4));
      check("t4_buffered", 64'(exp_q.size()), 64'(12));
      m_res_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      check("t4_drained", 64'(exp_q.size()), 64'(0));
`ifdef REGEX_JOB_SCHED_STATS_EN
      check("t4_stat_jobs", 64'(stat_jobs), 64'(16));
      check("t4_stat_matches", 64'(stat_matches), 64'(7));
`endif

      // Test 5: done pulses outside RUN are ignored
      do_reset();
      pulse_done(4'b0100, 4'b0100);
      repeat (3) tick();
      check("t5_idle_no_res", 64'(m_res_valid), 64'(0));
      check("t5_idle_busy", 64'(busy_mask), 64'(0));
      push_job(8'h40, 16'd20, 8'd20);
      push_job(8'h41, 16'd21, 8'd21);
      push_job(8'h42, 16'd22, 8'd22);
      tick();
      check("t5_issue_busy", 64'(busy_mask), 64'(4'b0111));
      pulse_done(4'b0100, 4'b0100);
      repeat (3) tick();
      check("t5_issue_no_res", 64'(m_res_valid), 64'(0));
      check("t5_issue_busy_kept", 64'(busy_mask), 64'(4'b0111));
      check("t5_issue_valid_kept", 64'(u_cmd_valid), 64'(4'b0111));

      // Test 6: reset with jobs in flight and queued
      u_cmd_ready = 4'b0111;
      tick();
      u_cmd_ready = 4'b0000;
      check("t6_running", 64'(u_cmd_valid), 64'(0));
      push_job(8'h43, 16'd23, 8'd23);
      push_job(8'h44, 16'd24, 8'd24);
      push_job(8'h45, 16'd25, 8'd25);
      check("t6_queued2", 64'(cmd_count), 64'(2));
      check("t6_busy_all", 64'(busy_mask), 64'(4'hF));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy_cleared", 64'(busy_mask), 64'(0));
      check("t6_count_cleared", 64'(cmd_count), 64'(0));
      check("t6_res_cleared", 64'(m_res_valid), 64'(0));
      check("t6_valid_cleared", 64'(u_cmd_valid), 64'(0));
      check("t6_ready_open", 64'(s_cmd_ready), 64'(1));
      pulse_done(4'hF, 4'hF);
      repeat (4) tick();
      check("t6_no_stale_res", 64'(m_res_valid), 64'(0));
      check("t6_no_stale_busy", 64'(busy_mask), 64'(0));
`ifdef REGEX_JOB_SCHED_STATS_EN
      check("t6_stat_jobs_cleared", 64'(stat_jobs), 64'(0));
`endif
      check("end_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
